// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator between the memory stage and a word-organised data memory.
// Sub-word stores are done as read-modify-write; loads are byte-lane selected and extended.
module lsu_mem_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic                     resp_err,
  output logic                     mem_wr_en,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wd,
  input  logic [DATA_WIDTH-1:0]    mem_rd
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [31:0]             addr_q, addr_d;
  logic [15:0]             wdata_lo_q, wdata_lo_d;
  logic [DATA_WIDTH-1:0]   wbuf_q, wbuf_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic                    req_bad;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;

  // Request legality check on the live request inputs
  always_comb begin
    req_bad = 1'b0;
    unique case (req_funct3)
      3'b000:  req_bad = 1'b0;
      3'b001:  req_bad = req_addr[0];
      3'b010:  req_bad = (req_addr[1:0] != 2'b00);
      3'b100:  req_bad = req_we;
      3'b101:  req_bad = req_we | req_addr[0];
      default: req_bad = 1'b1;
    endcase
  end

  // Byte and halfword lane selection from the memory read word
  always_comb begin
    byte_sel = '0;
    unique case (addr_q[1:0])
      2'd0: byte_sel = mem_rd[7:0];
      2'd1: byte_sel = mem_rd[15:8];
      2'd2: byte_sel = mem_rd[23:16];
      2'd3: byte_sel = mem_rd[31:24];
      default: byte_sel = '0;
    endcase
    half_sel = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
  end

  // Next-state and latched-register update
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_lo_d = wdata_lo_q;
    wbuf_d     = wbuf_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          funct3_d   = req_funct3;
          addr_d     = req_addr;
          wdata_lo_d = req_wdata[15:0];
          if (req_bad) begin
            // Response fields are only replaced when a response is formed
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else if (req_we && (req_funct3 == 3'b010)) begin
            wbuf_d  = req_wdata;
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: state_d = RDW;
      RDW: begin
        if (we_q) begin
          wbuf_d = mem_rd;
          if (funct3_q[1:0] == 2'b00) begin
            unique case (addr_q[1:0])
              2'd0: wbuf_d[7:0]   = wdata_lo_q[7:0];
              2'd1: wbuf_d[15:8]  = wdata_lo_q[7:0];
              2'd2: wbuf_d[23:16] = wdata_lo_q[7:0];
              2'd3: wbuf_d[31:24] = wdata_lo_q[7:0];
              default: wbuf_d = mem_rd;
            endcase
          end else if (addr_q[1]) begin
            wbuf_d[31:16] = wdata_lo_q;
          end else begin
            wbuf_d[15:0] = wdata_lo_q;
          end
          state_d = WR;
        end else begin
          unique case (funct3_q)
            3'b000:  rdata_d = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  rdata_d = {24'h0, byte_sel};
            3'b001:  rdata_d = {{16{half_sel[15]}}, half_sel};
            3'b101:  rdata_d = {16'h0, half_sel};
            default: rdata_d = mem_rd;
          endcase
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      WR: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_lo_q <= '0;
      wbuf_q     <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_lo_q <= wdata_lo_d;
      wbuf_q     <= wbuf_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Moore outputs decoded from state and latched registers
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_err   = err_q;
    resp_rdata = rdata_q;
    mem_wr_en  = (state_q == WR);
    mem_wd     = (state_q == WR) ? wbuf_q : '0;
  end

  // Word address fitted to ADDRESS_WIDTH by zero-extension or truncation
  if (ADDRESS_WIDTH > 30) begin : g_addr_ext
    assign mem_addr = {{(ADDRESS_WIDTH-30){1'b0}}, addr_q[31:2]};
  end else begin : g_addr_trunc
    assign mem_addr = addr_q[ADDRESS_WIDTH+1:2];
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl with a registered-read memory model.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic        pre_we;
  logic [4:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem [32];

  int checks = 0;
  int errors = 0;

  lsu_mem_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Word memory: registered read, write on mem_wr_en, backdoor preload port
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr[4:0]] <= mem_wd;
    else if (pre_we) mem[pre_addr] <= pre_data;
    mem_rd <= mem[mem_addr[4:0]];
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          nwr;
    logic [31:0] wd;
    logic [31:0] maddr;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL [%0d] %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          lat;
    int          nwr;
    logic [31:0] wd;
    logic [31:0] maddr1;
    logic [31:0] rdata;
    logic        err;
    bit          seen;
    lat = 0; nwr = 0; wd = '0; maddr1 = '0; rdata = '0; err = 1'b0; seen = 0;
    @(negedge clk);
    chk(idx, "req_ready_idle", {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) maddr1 = mem_addr;
      if (mem_wr_en) begin nwr++; wd = mem_wd; end
      if (resp_valid) begin seen = 1; lat = c; rdata = resp_rdata; err = resp_err; end
    end
    chk(idx, "latency", lat, v.lat);
    chk(idx, "resp_rdata", rdata, v.rdata);
    chk(idx, "resp_err", {31'h0, err}, {31'h0, v.err});
    chk(idx, "write_count", nwr, v.nwr);
    chk(idx, "mem_addr_c1", maddr1, v.maddr);
    if (v.nwr > 0) chk(idx, "mem_wd", wd, v.wd);
    @(negedge clk);
    chk(idx, "resp_single_pulse", {31'h0, resp_valid}, 32'd0);
    chk(idx, "resp_rdata_hold", resp_rdata, v.rdata);
  endtask

  initial begin
    logic [7:0] wr_mask, resp_mask, rdy_mask;
    logic [31:0] wd2;
    vec_t v;

    //            we    f3      addr   wdata         lat rdata         err nwr wd            maddr
    vecs[0]  = '{1'b0, 3'b000, 32'h17, 32'h0,         3, 32'hFFFFFF88, 1'b0, 0, 32'h0,        32'd5};
    vecs[1]  = '{1'b0, 3'b100, 32'h16, 32'h0,         3, 32'h00000099, 1'b0, 0, 32'h0,        32'd5};
    vecs[2]  = '{1'b0, 3'b101, 32'h14, 32'h0,         3, 32'h0000AABB, 1'b0, 0, 32'h0,        32'd5};
    vecs[3]  = '{1'b0, 3'b001, 32'h16, 32'h0,         3, 32'hFFFF8899, 1'b0, 0, 32'h0,        32'd5};
    vecs[4]  = '{1'b0, 3'b010, 32'h14, 32'h0,         3, 32'h8899AABB, 1'b0, 0, 32'h0,        32'd5};
    vecs[5]  = '{1'b1, 3'b000, 32'h15, 32'h123456CC,  4, 32'h0,        1'b0, 1, 32'h8899CCBB, 32'd5};
    vecs[6]  = '{1'b0, 3'b010, 32'h14, 32'h0,         3, 32'h8899CCBB, 1'b0, 0, 32'h0,        32'd5};
    vecs[7]  = '{1'b1, 3'b010, 32'h20, 32'hDEADBEEF,  2, 32'h0,        1'b0, 1, 32'hDEADBEEF, 32'd8};
    vecs[8]  = '{1'b0, 3'b010, 32'h20, 32'h0,         3, 32'hDEADBEEF, 1'b0, 0, 32'h0,        32'd8};
    vecs[9]  = '{1'b0, 3'b010, 32'h22, 32'h0,         1, 32'h0,        1'b1, 0, 32'h0,        32'd8};
    vecs[10] = '{1'b1, 3'b001, 32'h13, 32'h0000FFFF,  1, 32'h0,        1'b1, 0, 32'h0,        32'd4};
    vecs[11] = '{1'b1, 3'b100, 32'h14, 32'h000000AA,  1, 32'h0,        1'b1, 0, 32'h0,        32'd5};
    vecs[12] = '{1'b1, 3'b001, 32'h16, 32'hFFFF1234,  4, 32'h0,        1'b0, 1, 32'h1234CCBB, 32'd5};
    vecs[13] = '{1'b0, 3'b000, 32'h14, 32'h0,         3, 32'hFFFFFFBB, 1'b0, 0, 32'h0,        32'd5};
    vecs[14] = '{1'b0, 3'b100, 32'h15, 32'h0,         3, 32'h000000CC, 1'b0, 0, 32'h0,        32'd5};
    vecs[15] = '{1'b0, 3'b001, 32'h14, 32'h0,         3, 32'hFFFFCCBB, 1'b0, 0, 32'h0,        32'd5};
    vecs[16] = '{1'b1, 3'b000, 32'h17, 32'h0000007F,  4, 32'h0,        1'b0, 1, 32'h7F34CCBB, 32'd5};
    vecs[17] = '{1'b0, 3'b011, 32'h00, 32'h0,         1, 32'h0,        1'b1, 0, 32'h0,        32'd0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    pre_we = 1'b1; pre_addr = 5'd5; pre_data = 32'h8899AABB;
    repeat (3) @(negedge clk);
    pre_we = 1'b0;

    // Reset state
    chk(-1, "rst_req_ready", {31'h0, req_ready}, 32'd1);
    chk(-1, "rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    chk(-1, "rst_resp_err", {31'h0, resp_err}, 32'd0);
    chk(-1, "rst_resp_rdata", resp_rdata, 32'd0);
    chk(-1, "rst_mem_wr_en", {31'h0, mem_wr_en}, 32'd0);
    chk(-1, "rst_mem_addr", mem_addr, 32'd0);
    chk(-1, "rst_mem_wd", mem_wd, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

    // Back-to-back SW with req_valid held high
    wr_mask = '0; resp_mask = '0; rdy_mask = '0; wd2 = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'h11112222;
    @(posedge clk); #1;
    req_addr = 32'h24; req_wdata = 32'h33334444;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (mem_wr_en) wr_mask[c] = 1'b1;
      if (resp_valid) resp_mask[c] = 1'b1;
      if (req_ready) rdy_mask[c] = 1'b1;
      if (c == 4) begin
        wd2 = mem_wd;
        chk(100, "b2b_second_addr", mem_addr, 32'd9);
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
      end
    end
    chk(100, "b2b_wr_cycles", {24'h0, wr_mask}, 32'h12);
    chk(100, "b2b_resp_cycles", {24'h0, resp_mask}, 32'h24);
    chk(100, "b2b_ready_cycles", {24'h0, rdy_mask}, 32'hC8);
    chk(100, "b2b_second_wd", wd2, 32'h33334444);

    // Reset during RDW of an SB aborts it
    wr_mask = '0; resp_mask = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h14; req_wdata = 32'h00000055;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (mem_wr_en) wr_mask[c] = 1'b1;
      if (resp_valid) resp_mask[c] = 1'b1;
      if (c == 2) rst = 1'b1;
      if (c == 3) begin
        chk(200, "abort_ready_after_rst", {31'h0, req_ready}, 32'd1);
        rst = 1'b0;
      end
    end
    chk(200, "abort_no_write", {24'h0, wr_mask}, 32'h0);
    chk(200, "abort_no_resp", {24'h0, resp_mask}, 32'h0);

    v = '{1'b0, 3'b010, 32'h14, 32'h0, 3, 32'h7F34CCBB, 1'b0, 0, 32'h0, 32'd5};
    run_vec(201, v);
    v = '{1'b0, 3'b010, 32'h24, 32'h0, 3, 32'h33334444, 1'b0, 0, 32'h0, 32'd9};
    run_vec(202, v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator that sits between the pipeline's memory stage and the word-organised data memory.
- Accepts byte, halfword and word loads and stores, using RISC-V funct3 encoding.
- Performs read-modify-write for sub-word stores, because the memory only writes whole words.
- Sign- or zero-extends load data and flags misaligned or illegal accesses without touching memory.

Parameters:
- ADDRESS_WIDTH, 32: width of mem_addr (word index into data memory).
- DATA_WIDTH, 32: word width; the block is defined for 32 only.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request (high only in IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU legal for loads only).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; the low byte or halfword is used for B/H.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned or illegal request, valid with resp_valid.
- mem_wr_en  output  1  memory write enable.
- mem_addr  output  ADDRESS_WIDTH  word address = req_addr[31:2], zero-extended or truncated to ADDRESS_WIDTH.
- mem_wd  output  DATA_WIDTH  memory write data.
- mem_rd  input  DATA_WIDTH  memory read data; registered by memory, valid the cycle after the address is presented with mem_wr_en=0.

Behaviour:
- States: IDLE, RD, RDW, WR, RESP.
- Reset: state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_wr_en=0; mem_addr=0; mem_wd=0; internal latches cleared.
- IDLE: req_ready=1. A handshake occurs on req_valid&&req_ready at the clock edge. At that edge the block latches we, funct3, addr and wdata, then:
  - error if H/HU with addr[0]=1, W with addr[1:0]!=0, funct3 in {011,110,111}, or a store with funct3 100/101: go to RESP with err=1 and no memory access.
  - SW: go to WR with wbuf=wdata.
  - any load, SB or SH: go to RD.
- RD: mem_addr=latched word address, mem_wr_en=0; next state RDW.
- RDW: mem_rd is valid.
  - Load: select the byte (addr[1:0]) or halfword (addr[1]), then sign- or zero-extend per funct3 into resp_rdata; go to RESP.
  - Store: merge into wbuf by replacing only the addressed byte or halfword of mem_rd with req_wdata[7:0] or [15:0]; go to WR.
- WR: mem_wr_en=1, mem_addr=word address, mem_wd=wbuf; next state RESP. Only this state ever drives mem_wr_en=1.
- RESP: resp_valid=1 for exactly one cycle, resp_err as latched; next state IDLE. There is no response backpressure; the consumer must sample on the pulse.
- Outputs are Moore outputs decoded from state plus latched registers. mem_addr holds the latched value outside IDLE.
- Latency from the handshake edge to the resp_valid cycle:
  - LW/LH/LB: 3 cycles.
  - SW: 2 cycles.
  - SB/SH: 4 cycles.
  - error: 1 cycle.
- Throughput: next accept is at the earliest in the cycle after RESP. req_valid held high during busy states is ignored.
- resp_rdata and resp_err hold their values after RESP until the next response is formed.
- Reset mid-operation: the state returns to IDLE at the reset edge. A write already presented in the WR cycle commits at that same edge. No write is issued after the reset edge, and no resp_valid is produced for the aborted request.
- Little-endian byte lanes: addr[1:0]=0 selects bits [7:0]; 3 selects [31:24].

Test Plan:
- Reset, then mem word 5 = 0x8899AABB; load LB at addr 0x17 -> mem_addr=5 during RD; resp_rdata=0xFFFFFF88 three cycles after accept; resp_err=0.
- Same word: LBU 0x16 -> 0x00000099; LHU 0x14 -> 0x0000AABB; LH 0x16 -> 0xFFFF8899; LW 0x14 -> 0x8899AABB.
- SB addr 0x15, wdata 0x123456CC, word 5 = 0x8899AABB -> RD, RDW, then a single WR cycle with mem_wr_en=1, mem_wd=0x8899CCBB; resp_valid 4 cycles after accept.
- SW addr 0x20, wdata 0xDEADBEEF -> no read cycle; WR with mem_addr=8, mem_wd=0xDEADBEEF; resp_valid 2 cycles after accept.
- LW at 0x22, SH at 0x13, and SB with funct3=100 -> each produces resp_err=1 one cycle after accept, with mem_wr_en never asserted.
- Back-to-back: req_valid held high with two SW requests -> the second is accepted only in the IDLE cycle after the first RESP.
- Reset asserted during RDW of an SB -> no WR cycle occurs, no resp_valid, and req_ready=1 in the cycle after reset.
